// File: rtl/uart_pkg.sv
// uart_pkg: shared states, defaults and sampling-point helper for the oversampled UART receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  function automatic int vote_idx(input int os);
    return os / 2 + 1;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronizes the rx pin and majority-votes the last three ticked samples.
module uart_rx_sampler (
  input  logic clk,
  input  logic nReset,
  input  logic en,
  input  logic in,
  output logic sync,
  output logic vote
);
  logic [1:0] r_sync;
  logic [2:0] r_hist;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_sync <= '1;
      r_hist <= '1;
    end else begin
      r_sync <= {r_sync[0], in};
      if (en) r_hist <= {r_hist[1:0], r_sync[1]};
    end
  end
  assign sync = r_sync[1];
  assign vote = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with majority voting, false-start rejection and break detection.
module uart_rx_oversampled import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       en,
  input  logic       in,
  output logic [7:0] data,
  output logic       done,
  output logic       err,
  output logic       brk,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] VT = CW'(vote_idx(OVERSAMPLE));
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  rx_state_e r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [IW-1:0] r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [7:0] r_data, w_data_n;
  logic r_done, r_err, w_done_n, w_err_n;
  logic w_sync, w_vote, w_vt, w_wrap;
  uart_rx_sampler u_sampler (
    .clk(clk), .nReset(nReset), .en(en), .in(in), .sync(w_sync), .vote(w_vote)
  );
  assign w_vt = en && r_cnt == VT;
  assign w_wrap = r_cnt == LAST;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    if (en) begin
      w_cnt_n = w_wrap ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          w_cnt_n = w_sync ? '0 : CW'(1);
          w_state_n = w_sync ? IDLE : START;
        end
        START: begin
          if (w_vt && w_vote) begin
            w_state_n = IDLE;
            w_cnt_n = '0;
          end else if (w_wrap) begin
            w_state_n = DATA;
            w_idx_n = '0;
          end
        end
        DATA: begin
          if (w_vt) w_shift_n = {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            w_state_n = r_idx == LAST_BIT ? STOP : DATA;
            w_idx_n = r_idx == LAST_BIT ? r_idx : r_idx + 1'b1;
          end
        end
        STOP: begin
          // Finish at the stop-bit midpoint so a following start edge is never missed.
          if (w_vt) begin
            w_cnt_n = '0;
            w_done_n = w_vote;
            w_err_n = !w_vote;
            w_data_n = w_vote ? 8'(r_shift) : r_data;
            w_state_n = w_vote ? IDLE : (r_shift == '0 ? BREAK : IDLE);
          end
        end
        BREAK: begin
          w_cnt_n = '0;
          w_state_n = w_sync ? IDLE : BREAK;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end
  assign data = r_data;
  assign done = r_done;
  assign err  = r_err;
  assign brk  = r_state == BREAK;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: table-driven frames plus corner sequences, checked by a pulse scoreboard.
module tb_uart_rx_oversampled;
  localparam int BIT_CLK = 64;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;
  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       brk;
  } exp_t;
  logic clk = 0, nReset = 0, en = 0, in = 1;
  logic [7:0] data;
  logic done, err, brk, busy;
  int total = 0, bad = 0;
  int ecnt = 0;
  logic prev_busy = 0;
  exp_t q[$];
  vec_t tbl[5];
  uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .nReset(nReset), .en(en), .in(in),
    .data(data), .done(done), .err(err), .brk(brk), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    en = (ecnt == 0);
    ecnt = (ecnt + 1) % 4;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done && err) begin
      total++;
      bad++;
      $display("FAIL pulse_overlap done=%0b err=%0b required only one high", done, err);
    end else if (done || err) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse done=%0b err=%0b data=%02h required no pulse", done, err, data);
      end else begin
        e = q.pop_front();
        if (err != e.is_err || data != e.data || brk != e.brk || busy != e.brk || !prev_busy) begin
          bad++;
          $display("FAIL pulse err=%0b data=%02h brk=%0b busy=%0b prev_busy=%0b required err=%0b data=%02h brk=%0b busy=%0b prev_busy=1",
                   err, data, brk, busy, prev_busy, e.is_err, e.data, e.brk, e.brk);
        end
      end
    end
    prev_busy = busy;
  end
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int gap, input int glitch_bit);
    in = 0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in = d[i];
      if (i == glitch_bit) begin
        repeat (28) @(negedge clk);
        in = ~d[i];
        repeat (4) @(negedge clk);
        in = d[i];
        repeat (BIT_CLK - 32) @(negedge clk);
      end else repeat (BIT_CLK) @(negedge clk);
    end
    in = stop;
    repeat (BIT_CLK) @(negedge clk);
    in = 1;
    repeat (gap * BIT_CLK) @(negedge clk);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 4 * BIT_CLK && q.size() != 0; i++) @(negedge clk);
    chk(name, q.size(), 0);
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog expired required test completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};
    tbl[3] = '{8'h3C, 1'b0, 3, 1'b1, 8'hFF};
    tbl[4] = '{8'hC3, 1'b1, 1, 1'b0, 8'hC3};
    repeat (5) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_brk", brk, 0);
    chk("rst_busy", busy, 0);
    nReset = 1;
    repeat (2 * BIT_CLK) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      q.push_back('{tbl[i].exp_err, tbl[i].exp_data, 1'b0});
      send(tbl[i].d, tbl[i].stop, tbl[i].gap, -1);
    end
    drain("table_drain");
    chk("idle_busy", busy, 0);
    q.push_back('{1'b1, 8'hC3, 1'b1});
    in = 0;
    repeat (20 * BIT_CLK) @(negedge clk);
    drain("break_drain");
    chk("break_level", brk, 1);
    in = 1;
    for (int i = 0; i < 16 && brk; i++) @(negedge clk);
    chk("break_release", brk, 0);
    repeat (BIT_CLK) @(negedge clk);
    q.push_back('{1'b0, 8'h55, 1'b0});
    send(8'h55, 1'b1, 1, -1);
    drain("frame55_drain");
    in = 0;
    repeat (20) @(negedge clk);
    in = 1;
    chk("glitch_busy_rise", busy, 1);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("glitch_busy_fall", busy, 0);
    repeat (BIT_CLK) @(negedge clk);
    q.push_back('{1'b0, 8'h00, 1'b0});
    send(8'h00, 1'b1, 1, 3);
    drain("mask_drain");
    in = 0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in = i == 0;
      repeat (BIT_CLK) @(negedge clk);
    end
    in = 0;
    repeat (20) @(negedge clk);
    nReset = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_brk", brk, 0);
    chk("mid_rst_busy", busy, 0);
    in = 1;
    repeat (3) @(negedge clk);
    nReset = 1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    q.push_back('{1'b0, 8'h81, 1'b0});
    send(8'h81, 1'b1, 1, -1);
    drain("frame81_drain");
    chk("final_data", data, 8'h81);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
